// File: rtl/mem_access_stage.sv
// Memory-access stage: drives the data-memory req/ready handshake, aligns store lanes, extracts
// load data and registers MEM/WB. Define MEM_MISALIGN_CHECK_EN to trap misaligned accesses.
module mem_access_stage #(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned TIMEOUT = 15
) (
  input  logic             clk,
  input  logic             rst_n,
  // EX/MEM register
  input  logic             RegWriteM,
  input  logic [1:0]       ResultSrcM,
  input  logic             MemWriteM,
  input  logic [2:0]       Funct3M,
  input  logic [WIDTH-1:0] ALUResultM,
  input  logic [WIDTH-1:0] WriteDataM,
  input  logic [4:0]       RdM,
  input  logic [WIDTH-1:0] PCPlus4M,
  output logic             StallM,
  // data memory
  output logic             DMemReq,
  output logic             DMemWe,
  output logic [WIDTH-1:0] DMemAddr,
  output logic [3:0]       DMemBe,
  output logic [WIDTH-1:0] DMemWData,
  input  logic [WIDTH-1:0] DMemRData,
  input  logic             DMemReady,
  // MEM/WB register
  output logic             RegWriteW,
  output logic [1:0]       ResultSrcW,
  output logic [WIDTH-1:0] ALUResultW,
  output logic [WIDTH-1:0] ReadDataW,
  output logic [4:0]       RdW,
  output logic [WIDTH-1:0] PCPlus4W,
  output logic             BusErrW,
  output logic             MisalignW
);

  localparam logic [7:0] TimeoutCnt = 8'(TIMEOUT);

  typedef enum logic [0:0] {StIdle, StWait} state_e;

  state_e     state_q, state_d;
  logic [7:0] wait_cnt_q, wait_cnt_d;

  logic       is_load, mem_op, misalign, access;
  logic       timeout_hit, abort, stall;
  logic [1:0] lane, size;

  assign lane    = ALUResultM[1:0];
  // Funct3[1:0]: 00 byte, 01 half, otherwise word; Funct3[2] selects zero-extension.
  assign size    = Funct3M[1:0];
  assign is_load = (ResultSrcM == 2'b01);
  assign mem_op  = MemWriteM | is_load;

`ifdef MEM_MISALIGN_CHECK_EN
  always_comb begin
    misalign = 1'b0;
    if (mem_op) begin
      case (size)
        2'b00:   misalign = 1'b0;
        2'b01:   misalign = lane[0];
        default: misalign = |lane;
      endcase
    end
  end
`else
  assign misalign = 1'b0;
`endif

  assign access      = mem_op & ~misalign;
  assign timeout_hit = (state_q == StWait) && (wait_cnt_q == TimeoutCnt);
  // A ready arriving on the timeout cycle still completes the access.
  assign abort       = access & timeout_hit & ~DMemReady;
  assign stall       = access & ~DMemReady & ~abort;

  // FSM state register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      wait_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

  // FSM next state
  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    unique case (state_q)
      StIdle: begin
        if (access && !DMemReady) begin
          state_d    = StWait;
          wait_cnt_d = 8'd1;
        end
      end
      StWait: begin
        if (!access || DMemReady || timeout_hit) begin
          state_d    = StIdle;
          wait_cnt_d = '0;
        end else begin
          wait_cnt_d = wait_cnt_q + 8'd1;
        end
      end
    endcase
  end

  // FSM / bus outputs; request and stall are forced low while reset is asserted
  always_comb begin
    DMemReq   = rst_n & access;
    StallM    = rst_n & stall;
    DMemWe    = MemWriteM;
    DMemAddr  = {ALUResultM[WIDTH-1:2], 2'b00};
    DMemBe    = 4'b1111;
    DMemWData = WriteDataM;
    case (size)
      2'b00: begin
        DMemBe    = 4'b0001 << lane;
        DMemWData = {(WIDTH/8){WriteDataM[7:0]}};
      end
      2'b01: begin
        DMemBe    = lane[1] ? 4'b1100 : 4'b0011;
        DMemWData = {(WIDTH/16){WriteDataM[15:0]}};
      end
      default: ;
    endcase
  end

  // Load lane extraction and extension
  logic [7:0]       ld_byte;
  logic [15:0]      ld_half;
  logic [WIDTH-1:0] rdata_ext;

  always_comb begin
    unique case (lane)
      2'd0: ld_byte = DMemRData[7:0];
      2'd1: ld_byte = DMemRData[15:8];
      2'd2: ld_byte = DMemRData[23:16];
      2'd3: ld_byte = DMemRData[31:24];
    endcase
    ld_half   = lane[1] ? DMemRData[31:16] : DMemRData[15:0];
    rdata_ext = DMemRData;
    case (size)
      2'b00:   rdata_ext = {{(WIDTH-8){~Funct3M[2] & ld_byte[7]}}, ld_byte};
      2'b01:   rdata_ext = {{(WIDTH-16){~Funct3M[2] & ld_half[15]}}, ld_half};
      default: ;
    endcase
  end

  // MEM/WB register: bubbles clear the write controls and hold the datapath fields
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      RegWriteW  <= 1'b0;
      ResultSrcW <= 2'b00;
      ALUResultW <= '0;
      ReadDataW  <= '0;
      RdW        <= '0;
      PCPlus4W   <= '0;
      BusErrW    <= 1'b0;
      MisalignW  <= 1'b0;
    end else if (stall || abort || misalign) begin
      RegWriteW  <= 1'b0;
      ResultSrcW <= 2'b00;
      BusErrW    <= abort;
      MisalignW  <= misalign;
    end else begin
      RegWriteW  <= RegWriteM;
      ResultSrcW <= ResultSrcM;
      ALUResultW <= ALUResultM;
      ReadDataW  <= rdata_ext;
      RdW        <= RdM;
      PCPlus4W   <= PCPlus4M;
      BusErrW    <= 1'b0;
      MisalignW  <= 1'b0;
    end
  end

endmodule

// File: doc/mem_access_stage.md
# mem_access_stage

Memory-access stage of the 5-stage RISC-V pipeline: consumes the registered EX/MEM outputs, runs loads and stores against a variable-latency data memory over a req/ready handshake, and produces the registered MEM/WB outputs. It handles byte-lane alignment, load sign/zero extension and a wait-state timeout. It stalls the front of the pipe while a memory access is outstanding.

## Interface
- WIDTH, 32, datapath width
- TIMEOUT, 15, max WAIT cycles before bus-error abort (1..255)

- clk  in  1  pipeline clock
- rst_n  in  1  synchronous reset, active-low
- RegWriteM  in  1  register-write enable, M stage
- ResultSrcM  in  2  result select; 2'b01 = load
- MemWriteM  in  1  store enable
- Funct3M  in  3  access size/sign (RV32I load/store encoding)
- ALUResultM  in  WIDTH  effective address / ALU result
- WriteDataM  in  WIDTH  store data (unaligned, low bits)
- RdM  in  5  destination register
- PCPlus4M  in  WIDTH  PC+4
- StallM  out  1  hold IF/ID/EX/M registers this cycle
- DMemReq  out  1  memory request
- DMemWe  out  1  request is a store
- DMemAddr  out  WIDTH  word-aligned address ({ALUResultM[31:2],2'b00})
- DMemBe  out  4  byte enables
- DMemWData  out  WIDTH  lane-replicated store data
- DMemRData  in  WIDTH  read data, valid with DMemReady
- DMemReady  in  1  access complete this cycle
- RegWriteW, ResultSrcW[1:0], ALUResultW, ReadDataW, RdW[4:0], PCPlus4W  out  —  MEM/WB register
- BusErrW  out  1  timeout abort, one-cycle pulse with bubble
- MisalignW  out  1  misaligned access flagged (see Configuration)

## Operation
- MemOp = MemWriteM | (ResultSrcM==2'b01); non-MemOp instructions pass straight to the W register.
- FSM states IDLE, WAIT; 8-bit WaitCnt.
  - IDLE, MemOp: DMemReq=1. DMemReady=1 same cycle → complete, stay IDLE. Otherwise → WAIT, WaitCnt=1.
  - WAIT: DMemReq held with identical addr/be/data. DMemReady → complete, → IDLE. WaitCnt==TIMEOUT without ready → abort, → IDLE, WaitCnt=0; otherwise WaitCnt+1.
- StallM = MemOp & ~DMemReady & ~abort (combinational). Upstream holds M inputs stable while StallM=1.
- Store lanes: SB DMemBe=1<<a[1:0], data byte ×4. SH DMemBe=a[1]?1100:0011, data half ×2. SW 1111.
- Load extract from DMemRData by ALUResultM[1:0]: LB/LH sign-extend, LBU/LHU zero-extend, LW whole word.
- W register: every non-stall cycle loads M values; ReadDataW = extracted data. Stall cycle → bubble (RegWriteW=0, ResultSrcW=0, others hold). Abort → bubble with BusErrW=1, no regfile write.
- Stores never assert RegWriteW (RegWriteM is already 0 for stores; not forced).

## Timing
- Reset: all W outputs, BusErrW, MisalignW = 0; state IDLE; WaitCnt=0. DMemReq/StallM = 0 while rst_n=0. Reset in WAIT abandons the access; DMemReq is low from the reset cycle.
- Non-mem or zero-wait access: W outputs valid 1 edge after M inputs.
- N wait states: StallM high N cycles, N bubbles, result at edge of the ready cycle.
- Timeout: StallM high TIMEOUT cycles, then abort; DMemReady on the timeout cycle wins (completes normally).

## Configuration
- MEM_MISALIGN_CHECK_EN defined: SH/LH/LHU with a[0]≠0 or SW/LW with a[1:0]≠0 → no DMemReq, no stall, W bubble with MisalignW=1 for one cycle.
- Undefined: MisalignW tied 0; low address bits ignored for lane selection (SH/LH use a[1] only, SW/LW use the whole word).

## Test plan
- ADD result 0x1234, RdM=5, RegWriteM=1 → next edge ALUResultW=0x1234, RdW=5, RegWriteW=1, no DMemReq.
- SB addr 0x103, data 0xAB, ready same cycle → DMemBe=1000, DMemWData=0xABABABAB, DMemAddr=0x100, StallM=0.
- LB addr 0x101, DMemRData=0x0000_8000, ready after 3 waits → StallM 3 cycles, 3 bubbles, then ReadDataW=0xFFFF_FF80; LBU same gives 0x80.
- LW, ready never asserted, TIMEOUT=15 → StallM 15 cycles, BusErrW pulse, RegWriteW=0, FSM IDLE.
- rst_n low in WAIT cycle 2 → DMemReq, StallM, all W outputs 0; next load starts cleanly from IDLE.
- With MEM_MISALIGN_CHECK_EN, LW addr 0x102 → no DMemReq, MisalignW=1 one cycle, RegWriteW=0.
